spi_main_arbiter: RTL and testbench

- Shares one spi_main SPI master between NUM_REQ requesters, each owning one slave-select line.
- Round-robin grants a whole burst of len+1 words to one requester at a time and drives that requester's select low for the burst.
- Sequences each word through spi_main's TX valid/ready and done handshake, and routes received words back to the owner.
- Sits between client blocks and spi_main; spi_main's own o_SS is left unused.

---
 rtl/spi_main_arbiter.sv | 129 ++++++++++++
 tb/tb_spi_main_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_main_arbiter.sv
// spi_main_arbiter: round-robin burst arbiter sharing one spi_main among NUM_REQ slave selects; optional done watchdog under SPI_ARB_TIMEOUT_EN
module spi_main_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int LEN_WIDTH   = 4,
  parameter int SETUP_CYC   = 2,
  parameter int GUARD_CYC   = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              i_req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    i_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_tx_data,
  input  logic [NUM_REQ-1:0]              i_tx_valid,
  output logic [NUM_REQ-1:0]              o_tx_ready,
  output logic [NUM_REQ-1:0]              o_grant,
  output logic [DATA_WIDTH-1:0]           o_rx_data,
  output logic [NUM_REQ-1:0]              o_rx_valid,
  output logic [NUM_REQ-1:0]              o_ss_n,
  output logic                            o_busy,
`ifdef SPI_ARB_TIMEOUT_EN
  output logic [NUM_REQ-1:0]              o_timeout,
`endif
  output logic [DATA_WIDTH-1:0]           o_spi_data_in_TX,
  output logic                            o_spi_data_valid_TX,
  input  logic                            i_spi_data_ready_TX,
  input  logic                            i_spi_data_done,
  input  logic [DATA_WIDTH-1:0]           i_spi_data_out
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int SG = SETUP_CYC > GUARD_CYC ? SETUP_CYC : GUARD_CYC;
  localparam int MX = TIMEOUT_CYC > SG ? TIMEOUT_CYC : SG;
  localparam int TW = $clog2(MX + 1);
  typedef enum logic [2:0] {IDLE, SETUP, LOAD, WAIT_DONE, GUARD} state_t;
  state_t state;
  logic [IW-1:0] ptr, owner, pick;
  logic [LEN_WIDTH-1:0] cnt;
  logic [TW-1:0] tmr;
  logic take;
  // first requesting index at or after the round-robin pointer; lowest offset wins
  always_comb begin
    pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (i_req[IW'((int'(ptr) + k) % NUM_REQ)]) pick = IW'((int'(ptr) + k) % NUM_REQ);
  end
  assign take = (state == LOAD) && i_tx_valid[owner] && i_spi_data_ready_TX;
  assign o_tx_ready = NUM_REQ'(take) << owner;
  // burst sequencer: grant, setup delay, per-word load/done handshake, guard gap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      tmr <= '0;
      o_grant <= '0;
      o_ss_n <= '1;
      o_busy <= 1'b0;
      o_rx_data <= '0;
      o_rx_valid <= '0;
      o_spi_data_valid_TX <= 1'b0;
      o_spi_data_in_TX <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      o_timeout <= '0;
`endif
    end else begin
      o_rx_valid <= '0;
      o_spi_data_valid_TX <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      o_timeout <= '0;
`endif
      case (state)
        IDLE: if (|i_req) begin
          owner <= pick;
          o_grant <= NUM_REQ'(1) << pick;
          o_ss_n <= ~(NUM_REQ'(1) << pick);
          ptr <= (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
          cnt <= i_len[pick*LEN_WIDTH +: LEN_WIDTH];
          tmr <= '0;
          o_busy <= 1'b1;
          state <= SETUP;
        end
        SETUP: begin
          tmr <= tmr + 1'b1;
          state <= (tmr == TW'(SETUP_CYC - 1)) ? LOAD : SETUP;
        end
        LOAD: if (take) begin
          o_spi_data_valid_TX <= 1'b1;
          o_spi_data_in_TX <= i_tx_data[owner*DATA_WIDTH +: DATA_WIDTH];
          tmr <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (i_spi_data_done) begin
            o_rx_data <= i_spi_data_out;
            o_rx_valid <= o_grant;
            tmr <= '0;
            if (cnt == '0) begin
              o_grant <= '0;
              o_ss_n <= '1;
              state <= GUARD;
            end else begin
              cnt <= cnt - 1'b1;
              state <= LOAD;
            end
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (tmr == TW'(TIMEOUT_CYC - 1)) begin
            o_timeout <= o_grant;
            o_grant <= '0;
            o_ss_n <= '1;
            tmr <= '0;
            state <= GUARD;
          end else tmr <= tmr + 1'b1;
`endif
        end
        GUARD: begin
          tmr <= tmr + 1'b1;
          if (tmr == TW'(GUARD_CYC - 1)) begin
            o_busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_main_arbiter.sv
// tb_spi_main_arbiter: randomized directed bench for spi_main_arbiter with an spi_main stand-in and a round-robin reference model
module tb_spi_main_arbiter;
  localparam int N = 4, DW = 8, LW = 4, SC = 2, GC = 3;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] i_req, i_tx_valid, o_tx_ready, o_grant, o_rx_valid, o_ss_n;
  logic [N*LW-1:0] i_len;
  logic [N*DW-1:0] i_tx_data;
  logic [DW-1:0] o_rx_data, o_spi_data_in_TX, i_spi_data_out;
  logic o_busy, o_spi_data_valid_TX, i_spi_data_ready_TX, i_spi_data_done;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [N-1:0] o_timeout;
  logic [N-1:0] to_q[$];
  int to_cyc;
`endif
  int checks = 0, errors = 0;
  int mptr = 0, spi_dly = 3, spi_cnt = 0, cyc = 0, v_cyc = 0, hi_run = 0, bad_oh = 0, bad_ss = 0;
  int midx[N], idx[N], lens[N];
  logic hold = 1'b0;
  logic [DW-1:0] spi_cap;
  logic [DW-1:0] w[N][512];
  logic [N-1:0] prev_g = '0;
  logic [N-1:0] acc;
  int gnt_q[$], gaps[$], eg[$], eo[$];
  logic [DW-1:0] spi_q[$], rx_q[$], ew[$];
  logic [N-1:0] spi_ss[$], rx_oh[$];

  spi_main_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .SETUP_CYC(SC),
                     .GUARD_CYC(GC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_len(i_len), .i_tx_data(i_tx_data),
    .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready), .o_grant(o_grant), .o_rx_data(o_rx_data),
    .o_rx_valid(o_rx_valid), .o_ss_n(o_ss_n), .o_busy(o_busy),
`ifdef SPI_ARB_TIMEOUT_EN
    .o_timeout(o_timeout),
`endif
    .o_spi_data_in_TX(o_spi_data_in_TX), .o_spi_data_valid_TX(o_spi_data_valid_TX),
    .i_spi_data_ready_TX(i_spi_data_ready_TX), .i_spi_data_done(i_spi_data_done),
    .i_spi_data_out(i_spi_data_out));

  always #5 clk = ~clk;

  function automatic logic [N-1:0] oh(int k);
    return N'(1) << k;
  endfunction
  function automatic logic [N-1:0] ssel(int k);
    return ~(N'(1) << k);
  endfunction
  function automatic int ohidx(logic [N-1:0] v);
    int r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // requester side: offers w[k][idx[k]] and advances when the arbiter accepts
  initial begin
    i_tx_data = '0;
    forever begin
      @(negedge clk);
      acc = o_tx_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k]) idx[k]++;
        i_tx_data[k*DW +: DW] = w[k][idx[k]];
      end
    end
  end

  // spi_main stand-in: takes a word on valid, answers its inverse after spi_dly cycles
  initial begin
    i_spi_data_ready_TX = 1'b0;
    i_spi_data_done = 1'b0;
    i_spi_data_out = '0;
    forever begin
      @(posedge clk);
      #1;
      i_spi_data_done = 1'b0;
      if (spi_cnt > 0) begin
        spi_cnt--;
        if (spi_cnt == 0) begin
          i_spi_data_done = 1'b1;
          i_spi_data_out = spi_cap ^ 8'hFF;
        end
      end else if (o_spi_data_valid_TX) begin
        spi_cap = o_spi_data_in_TX;
        spi_cnt = spi_dly;
        i_spi_data_ready_TX = 1'b0;
      end else i_spi_data_ready_TX = !hold;
    end
  end

  // observation: log words, rx pulses, grants with preceding all-high run, invariants
  always @(negedge clk) begin
    cyc++;
    if (o_spi_data_valid_TX) begin
      spi_q.push_back(o_spi_data_in_TX);
      spi_ss.push_back(o_ss_n);
      v_cyc = cyc;
    end
    if (|o_rx_valid) begin
      rx_q.push_back(o_rx_data);
      rx_oh.push_back(o_rx_valid);
    end
`ifdef SPI_ARB_TIMEOUT_EN
    if (|o_timeout) begin
      to_q.push_back(o_timeout);
      to_cyc = cyc;
    end
`endif
    if (|o_grant && prev_g == '0) begin
      gnt_q.push_back(ohidx(o_grant));
      gaps.push_back(hi_run);
    end
    hi_run = (&o_ss_n) ? hi_run + 1 : 0;
    if ($countones(o_grant) > 1) bad_oh++;
    if (o_ss_n !== ~o_grant) bad_ss++;
    prev_g = o_grant;
  end

  // model the expected grants and word stream, then request until n grants were seen
  task automatic start_set(logic [N-1:0] mask, int n);
    int g;
    gnt_q.delete(); gaps.delete(); spi_q.delete(); spi_ss.delete(); rx_q.delete(); rx_oh.delete();
    eg.delete(); ew.delete(); eo.delete();
    for (int b = 0; b < n; b++) begin
      g = 0;
      for (int j = N - 1; j >= 0; j--) if (mask[(mptr + j) % N]) g = (mptr + j) % N;
      eg.push_back(g);
      mptr = (g + 1) % N;
      for (int j = 0; j <= lens[g]; j++) begin
        ew.push_back(w[g][midx[g]]);
        eo.push_back(g);
        midx[g]++;
      end
    end
    for (int k = 0; k < N; k++) i_len[k*LW +: LW] = LW'(lens[k]);
    i_req = mask;
    for (int t = 0; t < n * 300 && gnt_q.size() < n; t++) @(negedge clk);
    chk("grants_seen", gnt_q.size(), n);
    @(posedge clk);
    #1 i_req = '0;
  endtask

  task automatic finish_set();
    for (int t = 0; t < 3000 && rx_q.size() < ew.size(); t++) @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("guard_ss", o_ss_n, 4'hF);
    end
    for (int t = 0; t < 50 && o_busy; t++) @(negedge clk);
    chk("idle_busy", o_busy, 0);
    chk("n_grants", gnt_q.size(), eg.size());
    for (int b = 0; b < eg.size() && b < gnt_q.size(); b++) begin
      chk("grant", gnt_q[b], eg[b]);
      chk("gap", gaps[b] >= GC + 1, 1);
    end
    chk("n_words", spi_q.size(), ew.size());
    chk("n_rx", rx_q.size(), ew.size());
    for (int i = 0; i < ew.size(); i++) begin
      if (i < spi_q.size()) begin
        chk("spi_word", spi_q[i], ew[i]);
        chk("spi_ss", spi_ss[i], ssel(eo[i]));
      end
      if (i < rx_q.size()) begin
        chk("rx_word", rx_q[i], ew[i] ^ 8'hFF);
        chk("rx_owner", rx_oh[i], oh(eo[i]));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int bad, sz;
    reset = 1'b0;
    i_req = '0;
    i_len = '0;
    i_tx_valid = '1;
    for (int k = 0; k < N; k++) for (int i = 0; i < 512; i++) w[k][i] = DW'($urandom);
    #12;
    chk("rst_grant", o_grant, 0);
    chk("rst_ss", o_ss_n, 4'hF);
    chk("rst_busy", o_busy, 0);
    chk("rst_rxv", o_rx_valid, 0);
    chk("rst_rxd", o_rx_data, 0);
    chk("rst_txr", o_tx_ready, 0);
    chk("rst_spiv", o_spi_data_valid_TX, 0);
    chk("rst_spid", o_spi_data_in_TX, 0);
`ifdef SPI_ARB_TIMEOUT_EN
    chk("rst_to", o_timeout, 0);
`endif
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // single burst from requester 1, three fixed words
    w[1][midx[1]] = 8'hA5;
    w[1][midx[1] + 1] = 8'h3C;
    w[1][midx[1] + 2] = 8'hFF;
    lens = '{0, 2, 0, 0};
    start_set(4'b0010, 1);
    finish_set();
    // backpressure: spi_main not ready for 20+ cycles
    hold = 1'b1;
    lens = '{0, 0, 0, 0};
    start_set(4'b0100, 1);
    bad = 0;
    repeat (SC + 20) begin
      @(negedge clk);
      if (o_tx_ready != '0 || o_spi_data_valid_TX) bad++;
    end
    chk("bp_quiet", bad, 0);
    hold = 1'b0;
    finish_set();
    // owner stalls i_tx_valid and drops i_req mid-burst
    i_tx_valid = 4'b1110;
    lens = '{1, 0, 0, 0};
    start_set(4'b0001, 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_ss_n[0] !== 1'b0 || o_spi_data_valid_TX) bad++;
    end
    chk("stall_hold", bad, 0);
    @(posedge clk);
    #1 i_tx_valid = '1;
    finish_set();
    // asynchronous reset during the second word
    spi_dly = 10;
    lens = '{0, 0, 0, 3};
    start_set(4'b1000, 1);
    for (int t = 0; t < 300 && spi_q.size() < 2; t++) @(negedge clk);
    chk("rst_mid_words", spi_q.size(), 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_ss", o_ss_n, 4'hF);
    chk("arst_grant", o_grant, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_txr", o_tx_ready, 0);
    midx[3] -= 2;
    mptr = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    sz = rx_q.size();
    repeat (spi_dly + 5) @(posedge clk);
    #1;
    chk("stray_done", rx_q.size(), sz);
    // round robin with 0,1,3 held
    spi_dly = 2;
    lens = '{0, 0, 0, 0};
    start_set(4'b1011, 6);
    finish_set();
    // randomized masks, lengths and spi latency
    for (int r = 0; r < 6; r++) begin
      spi_dly = $urandom_range(1, 5);
      for (int k = 0; k < N; k++) lens[k] = $urandom_range(0, 3);
      start_set(N'($urandom_range(1, 15)), $urandom_range(1, 4));
      finish_set();
    end
    chk("grant_onehot", bad_oh, 0);
    chk("ss_matches_grant", bad_ss, 0);
`ifdef SPI_ARB_TIMEOUT_EN
    // spi_main never answers: watchdog aborts the burst
    spi_dly = 1000000;
    to_q.delete();
    lens = '{0, 2, 0, 0};
    start_set(4'b0010, 1);
    for (int t = 0; t < 300 && to_q.size() == 0; t++) @(negedge clk);
    chk("to_count", to_q.size(), 1);
    if (to_q.size() > 0) chk("to_owner", to_q[0], 4'b0010);
    chk("to_lat", (to_cyc - v_cyc >= TO) && (to_cyc - v_cyc <= TO + 1), 1);
    chk("to_no_rx", rx_q.size(), 0);
    for (int t = 0; t < 50 && o_busy; t++) @(negedge clk);
    chk("to_idle", o_busy, 0);
    chk("to_ss", o_ss_n, 4'hF);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
